clock_set_ctrl: RTL and testbench
=================================

// Module: clock_set_ctrl
// PURPOSE
//  Single-clock timekeeping and time-set controller for the 4-digit clock display.
//  Generates the 1 s tick, sequences the sec -> min -> hour BCD counters, and runs the
//  set-mode FSM that lets the user edit hours/minutes with two push buttons (TSW bits).
//  Its outputs feed the 7-segment decoders (hour/min digits) and the seconds LED bar.
// PARAMETERS
//  TICK_DIV    1024  pCLK cycles per seconds tick (>=2)
//  DEB_CYCLES  16    consecutive stable cycles required to accept a button level
//  BLINK_DIV   512   pCLK cycles per blink phase (used only with CLOCK_SET_BLINK_EN)
// PORTS
//  pCLK      in   1  system clock; all state on its rising edge
//  nRST      in   1  asynchronous, active-low reset
//  btn_mode  in   1  raw mode button, 1 = pressed, asynchronous to pCLK
//  btn_inc   in   1  raw increment button, 1 = pressed, asynchronous to pCLK
//  hr_t      out  4  hour tens BCD (0..1)
//  hr_u      out  4  hour units BCD (0..9)
//  min_t     out  4  minute tens BCD (0..5)
//  min_u     out  4  minute units BCD (0..9)
//  sec       out  6  seconds, binary 0..59
//  mode      out  2  00 RUN, 01 SET_HR, 10 SET_MIN (11 unused)
//  sec_tick  out  1  one-cycle pulse on every accepted seconds tick
//  blink     out  4  digit blank mask {hr_t,hr_u,min_t,min_u}, 1 = blank
// BEHAVIOUR
//  - Reset (async, nRST=0): all outputs 0, FSM=RUN, prescaler=0, debouncers idle.
//  - Buttons: 2-flop synchroniser, then debounce; edge pulse 1 cycle after the level has
//    been stable DEB_CYCLES cycles. Only press edges (0->1) generate pulses.
//  - Prescaler counts 0..TICK_DIV-1 in RUN only; at TICK_DIV-1 it wraps and issues tick.
//  - RUN, tick: sec+1; sec 59->0 carries to min_u; min_u 9->0 carries to min_t; min_t
//    5->0 carries to hours; hours 11->00 (12-hour range 00..11, no AM/PM). 11:59:59 -> 00:00:00
//    in one cycle. sec_tick pulses with the update. All outputs registered, update the
//    cycle after the tick.
//  - FSM: RUN --mode--> SET_HR --mode--> SET_MIN --mode--> RUN.
//  - SET_HR: prescaler and sec held; inc pulse -> hours+1, 11->00, no other digit touched.
//  - SET_MIN: prescaler and sec held; inc pulse -> minutes+1, 59->00, no carry to hours.
//  - Leaving SET_MIN -> RUN: sec := 0, prescaler := 0 (first tick TICK_DIV cycles later).
//  - mode and inc pulses in the same cycle: mode wins, inc discarded.
//  - inc in RUN: ignored. sec_tick never pulses outside RUN.
//  - Reset asserted mid-edit: immediate return to 00:00:00, RUN; no partial edit kept.
// CONFIGURATION
//  CLOCK_SET_BLINK_EN defined: blink counter toggles phase every BLINK_DIV cycles; in
//   SET_HR blink = {ph,ph,0,0}, in SET_MIN blink = {0,0,ph,ph}, in RUN blink = 0. Phase
//   counter cleared on every FSM transition (edited digits start visible).
//  Not defined: blink tied to 4'b0000, no blink counter synthesised.
// STRUCTURE
//  Package clock_pkg: mode encoding (MODE_RUN/MODE_SET_HR/MODE_SET_MIN), BCD limits
//   (SEC_MAX=59, MIN_T_MAX=5, HR_MAX_T=1, HR_MAX_U=1), shared with the 7-seg decoder.
//  Sub-module btn_debounce (param DEB_CYCLES; in: pCLK, nRST, raw; out: level, press_pulse),
//   instantiated twice. FSM, prescaler and BCD counters stay in this module.
// TESTING (TICK_DIV=4, DEB_CYCLES=3, BLINK_DIV=2)
//  1 Reset then run 240 cycles -> 60 sec_ticks, sec=0, min=01, hours=00.
//  2 Preload 11:59:58 via set mode, run 2 ticks -> 11:59:59 then 00:00:00 same cycle carry.
//  3 btn_mode pulse once, btn_inc 12 presses -> mode=01, hours walk 01..11 then 00.
//  4 Mode to SET_MIN, 60 inc presses from 00 -> back to 00, hours unchanged; mode -> RUN
//    clears sec to 0, first sec_tick exactly 4 cycles later.
//  5 btn_inc glitch high 2 cycles -> no pulse; mode+inc accepted same cycle -> only mode advances.
//  6 nRST low during SET_MIN with min=37 -> outputs 0, mode=00 without a pCLK edge.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the clock display: mode encoding, BCD limits and
// digit-pair increment helpers used by the time-set controller.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'b00,
        MODE_SET_HR  = 2'b01,
        MODE_SET_MIN = 2'b10
    } mode_t;

    localparam logic [5:0] SEC_MAX   = 6'd59;
    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic [3:0] MIN_T_MAX = 4'd5;
    localparam logic [3:0] HR_MAX_T  = 4'd1;
    localparam logic [3:0] HR_MAX_U  = 4'd1;

    typedef struct packed {
        logic [3:0] t;
        logic [3:0] u;
    } bcd2_t;

    // Hours run 00..11 and wrap to 00.
    function automatic bcd2_t hr_inc(input bcd2_t h);
        bcd2_t r;
        if (h.t == HR_MAX_T && h.u == HR_MAX_U) r = '0;
        else if (h.u == DIGIT_MAX)               r = '{t: h.t + 4'd1, u: 4'd0};
        else                                     r = '{t: h.t, u: h.u + 4'd1};
        return r;
    endfunction

    // Minutes run 00..59 and wrap to 00; the caller decides about the hour carry.
    function automatic bcd2_t min_inc(input bcd2_t m);
        bcd2_t r;
        if (m.u != DIGIT_MAX)       r = '{t: m.t, u: m.u + 4'd1};
        else if (m.t == MIN_T_MAX)  r = '0;
        else                        r = '{t: m.t + 4'd1, u: 4'd0};
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stable-level debounce and a
// one-cycle pulse on each accepted press (0->1) edge.
module btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic pCLK,
    input  logic nRST,
    input  logic raw,
    output logic level,
    output logic press_pulse
);

    localparam int             CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge pCLK or negedge nRST) begin
        if (!nRST) begin
            sync        <= '0;
            cnt         <= '0;
            level       <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values;
            // blocking here would collapse the synchroniser into a single stage.
            sync        <= {sync[0], raw};
            press_pulse <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level       <= sync[1];
                press_pulse <= sync[1];
                cnt         <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Timekeeping and time-set controller: 1 s prescaler, BCD sec/min/hour chain and
// the RUN/SET_HR/SET_MIN edit FSM. Digit blinking is built only with CLOCK_SET_BLINK_EN.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV   = 1024,
    parameter int DEB_CYCLES = 16,
    parameter int BLINK_DIV  = 512
) (
    input  logic       pCLK,
    input  logic       nRST,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] hr_t,
    output logic [3:0] hr_u,
    output logic [3:0] min_t,
    output logic [3:0] min_u,
    output logic [5:0] sec,
    output logic [1:0] mode,
    output logic       sec_tick,
    output logic [3:0] blink
);

    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    if (TICK_DIV < 2 || BLINK_DIV < 2) begin : g_param_check
        $error("clock_set_ctrl: TICK_DIV and BLINK_DIV must be at least 2");
    end

    logic mode_pulse, inc_pulse;
    logic mode_level_unused, inc_level_unused;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .pCLK(pCLK), .nRST(nRST), .raw(btn_mode),
        .level(mode_level_unused), .press_pulse(mode_pulse)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .pCLK(pCLK), .nRST(nRST), .raw(btn_inc),
        .level(inc_level_unused), .press_pulse(inc_pulse)
    );

    mode_t state, next_state;

    always_ff @(posedge pCLK or negedge nRST) begin
        if (!nRST) state <= MODE_RUN;
        else       state <= next_state;
    end

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        if (mode_pulse) begin
            case (state)
                MODE_RUN:    next_state = MODE_SET_HR;
                MODE_SET_HR: next_state = MODE_SET_MIN;
                default:     next_state = MODE_RUN;
            endcase
        end
    end

    logic          run, tick, inc_ok, leave_min;
    logic [PW-1:0] presc;
    bcd2_t         hr, mn;

    assign run       = (state == MODE_RUN);
    assign tick      = run && (presc == TICK_LAST);
    assign inc_ok    = inc_pulse && !mode_pulse;  // mode wins over a coincident inc
    assign leave_min = mode_pulse && (state == MODE_SET_MIN);

    always_ff @(posedge pCLK or negedge nRST) begin
        if (!nRST) begin
            presc    <= '0;
            sec      <= '0;
            mn       <= '0;
            hr       <= '0;
            sec_tick <= 1'b0;
        end else begin
            sec_tick <= tick;
            if (leave_min) begin
                sec   <= '0;
                presc <= '0;
            end else if (run) begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick) begin
                    if (sec == SEC_MAX) begin
                        sec <= '0;
                        mn  <= min_inc(mn);
                        if (mn == '{t: MIN_T_MAX, u: DIGIT_MAX}) hr <= hr_inc(hr);
                    end else begin
                        sec <= sec + 6'd1;
                    end
                end
            end
            if (state == MODE_SET_HR && inc_ok)  hr <= hr_inc(hr);
            if (state == MODE_SET_MIN && inc_ok) mn <= min_inc(mn);
        end
    end

    assign hr_t  = hr.t;
    assign hr_u  = hr.u;
    assign min_t = mn.t;
    assign min_u = mn.u;
    assign mode  = state;

`ifdef CLOCK_SET_BLINK_EN
    localparam int            BW         = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt;
    logic          ph;

    // Phase restarts on every mode change so freshly selected digits start visible.
    always_ff @(posedge pCLK or negedge nRST) begin
        if (!nRST) begin
            blink_cnt <= '0;
            ph        <= 1'b0;
        end else if (next_state != state) begin
            blink_cnt <= '0;
            ph        <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            ph        <= ~ph;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        blink = 4'b0000;
        case (state)
            MODE_SET_HR:  blink = {ph, ph, 2'b00};
            MODE_SET_MIN: blink = {2'b00, ph, ph};
            default:      blink = 4'b0000;
        endcase
    end
`else
    assign blink = 4'b0000;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with TICK_DIV=4, DEB_CYCLES=3, BLINK_DIV=2.
module tb_clock_set_ctrl;

    logic       pCLK = 1'b0;
    logic       nRST = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] hr_t, hr_u, min_t, min_u, blink;
    logic [5:0] sec;
    logic [1:0] mode;
    logic       sec_tick;

    int total = 0;
    int bad   = 0;

    clock_set_ctrl #(.TICK_DIV(4), .DEB_CYCLES(3), .BLINK_DIV(2)) dut (
        .pCLK(pCLK), .nRST(nRST), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .hr_t(hr_t), .hr_u(hr_u), .min_t(min_t), .min_u(min_u),
        .sec(sec), .mode(mode), .sec_tick(sec_tick), .blink(blink)
    );

    always #5 pCLK = ~pCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge pCLK);
    endtask

    task automatic press_inc();
        btn_inc = 1'b1; cyc(8);
        btn_inc = 1'b0; cyc(8);
    endtask

    task automatic press_mode();
        btn_mode = 1'b1; cyc(8);
        btn_mode = 1'b0; cyc(8);
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, "_hr_t"},  32'(hr_t),  32'(h / 10));
        check({tag, "_hr_u"},  32'(hr_u),  32'(h % 10));
        check({tag, "_min_t"}, 32'(min_t), 32'(m / 10));
        check({tag, "_min_u"}, 32'(min_u), 32'(m % 10));
        check({tag, "_sec"},   32'(sec),   32'(s));
    endtask

    task automatic check_zero(input string tag);
        check_time(tag, 0, 0, 0);
        check({tag, "_mode"},  32'(mode),     32'd0);
        check({tag, "_tick"},  32'(sec_tick), 32'd0);
        check({tag, "_blink"}, 32'(blink),    32'd0);
    endtask

    // Leave SET_MIN: sec must be 0 and the first tick lands exactly 4 cycles later.
    task automatic mode_to_run(input string tag);
        bit found = 1'b0;
        btn_mode = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge pCLK);
            if (mode == 2'b00) found = 1'b1;
        end
        check({tag, "_run_seen"}, 32'(found), 32'd1);
        check({tag, "_sec_clr"},  32'(sec),   32'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge pCLK);
            check($sformatf("%s_tick_c%0d", tag, k), 32'(sec_tick), (k == 4) ? 32'd1 : 32'd0);
        end
        btn_mode = 1'b0;
    endtask

    initial begin
        int ticks;

        // 1: reset state, then 240 cycles of free run
        cyc(2);
        check_zero("reset");
        nRST  = 1'b1;
        ticks = 0;
        for (int i = 0; i < 240; i++) begin
            @(negedge pCLK);
            if (sec_tick) ticks++;
        end
        check("run_ticks", 32'(ticks), 32'd60);
        check_time("run240", 0, 1, 0);
        check("run_mode", 32'(mode), 32'd0);

        // 2: preload 11:58 via set mode, run to 11:59:58 and across the full rollover
        nRST = 1'b0; cyc(1); nRST = 1'b1;
        press_mode();
        check("p_mode_hr", 32'(mode), 32'd1);
        repeat (11) press_inc();
        check("p_hr_t", 32'(hr_t), 32'd1);
        check("p_hr_u", 32'(hr_u), 32'd1);
        press_mode();
        check("p_mode_min", 32'(mode), 32'd2);
        repeat (58) press_inc();
        check("p_min_t", 32'(min_t), 32'd5);
        check("p_min_u", 32'(min_u), 32'd8);
        check("p_blink_min", 32'(mode), 32'd2);
        mode_to_run("pre");
        cyc(468);
        check_time("t_115958", 11, 59, 58);
        cyc(4);
        check_time("t_115959", 11, 59, 59);
        cyc(3);
        check_time("t_hold", 11, 59, 59);
        cyc(1);
        check_time("t_wrap", 0, 0, 0);
        check("t_wrap_tick", 32'(sec_tick), 32'd1);
        cyc(8);

        // 3: SET_HR walk 01..11 then 00, minutes untouched
        press_mode();
        check("h_mode", 32'(mode), 32'd1);
        for (int i = 1; i <= 12; i++) begin
            press_inc();
            check($sformatf("h_walk%0d", i), 32'(hr_t * 10 + hr_u), 32'(i % 12));
        end
        check("h_min_t", 32'(min_t), 32'd0);
        check("h_min_u", 32'(min_u), 32'd0);
        check("h_no_tick", 32'(sec_tick), 32'd0);

        // 4: SET_MIN full lap, no carry into hours, exit restarts seconds
        press_mode();
        check("m_mode", 32'(mode), 32'd2);
        for (int i = 1; i <= 60; i++) begin
            press_inc();
            check($sformatf("m_walk%0d", i), 32'(min_t * 10 + min_u), 32'(i % 60));
        end
        check("m_hr", 32'(hr_t * 10 + hr_u), 32'd0);
        mode_to_run("m");
        check("m_blink_run", 32'(blink), 32'd0);
        cyc(8);

        // 5: short inc glitch is rejected; coincident mode+inc advances mode only
        press_mode();
        check("g_mode", 32'(mode), 32'd1);
        btn_inc = 1'b1; cyc(2);
        btn_inc = 1'b0; cyc(10);
        check("g_glitch_hr", 32'(hr_t * 10 + hr_u), 32'd0);
        press_inc();
        check("g_real_hr", 32'(hr_t * 10 + hr_u), 32'd1);
        btn_mode = 1'b1; btn_inc = 1'b1; cyc(8);
        btn_mode = 1'b0; btn_inc = 1'b0; cyc(8);
        check("g_both_mode", 32'(mode), 32'd2);
        check("g_both_hr",   32'(hr_t * 10 + hr_u), 32'd1);
        check("g_both_min",  32'(min_t * 10 + min_u), 32'd0);

        // 6: asynchronous reset in the middle of a minute edit
        repeat (37) press_inc();
        check("r_min37", 32'(min_t * 10 + min_u), 32'd37);
        #2 nRST = 1'b0;
        #1 check_zero("r_async");
        @(negedge pCLK) nRST = 1'b1;
        cyc(2);
        check("r_mode_after", 32'(mode), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
